vending_machine_p: RTL and testbench
====================================

# vending_machine_p

Parametrised multi-coin vending controller; successor to the single-token vending FSM. Accepts three coin denominations, accumulates credit against a configurable price, issues a one-cycle vend pulse, then returns change one unit per cycle. Supports cancel/refund, rejects coins while busy and keeps a wrapping sales counter. Sits between the coin acceptor front-end and the dispenser/change-hopper drivers.

## Interface
Parameters:
- PRICE, 3, product price in units; must be ≥ 1
- COIN3_VAL, 5, value of denomination code 2'b11; codes 01 and 10 are fixed at 1 and 2 units
- CW, 4, credit register width; must satisfy 2^CW > PRICE-1+COIN3_VAL
- CNT_W, 8, sales counter width

Ports:
- clk  in  1  clock; all registers update on the rising edge
- rst  in  1  asynchronous, active-high reset
- coin  in  2  00 none, 01 = 1 unit, 10 = 2 units, 11 = COIN3_VAL; sampled each rising edge
- cancel  in  1  refund request, sampled each rising edge
- vend  out  1  high for exactly one cycle per sale
- chg  out  1  high for one cycle per change unit returned
- coin_rej  out  1  one-cycle pulse: previous-cycle coin was rejected and must be returned
- busy  out  1  high in VEND and CHANGE
- credit  out  CW  current credit or remaining change
- sales  out  CNT_W  number of completed sales, wraps modulo 2^CNT_W

## Operation
- States, 2-bit: IDLE (credit = 0), COLLECT (0 < credit < PRICE), VEND, CHANGE. All outputs registered or decoded from state only (Moore).
- IDLE/COLLECT, coin ≠ 00, cancel = 0: sum = credit + value.
  - sum ≥ PRICE → VEND, credit ← sum − PRICE.
  - Otherwise → COLLECT, credit ← sum.
- COLLECT, cancel = 1: → CHANGE with credit unchanged. A coin in the same cycle is rejected (coin_rej); cancel has priority.
- IDLE, cancel = 1: ignored. A coin in the same cycle is accepted normally.
- VEND (one cycle):
  - vend = 1; sales increments at the exit edge.
  - Exit to CHANGE if credit > 0, else to IDLE.
- CHANGE:
  - chg = 1 every cycle; credit decrements by 1 at each edge.
  - When credit = 1 at the edge → IDLE with credit = 0.
  - CHANGE is only entered with credit > 0.
- Any coin ≠ 00 presented in VEND or CHANGE: credit unaffected, coin_rej = 1 the next cycle. cancel is ignored in VEND and CHANGE.
- busy = (state == VEND || state == CHANGE).
- Arithmetic is unsigned in CW+1 bits for the comparison. Credit never exceeds PRICE − 1 + COIN3_VAL. The sales counter wraps silently from 2^CNT_W − 1 to 0.
- PRICE = 1: every accepted coin goes directly to VEND.

## Timing
- Reset values, applied asynchronously and immediately:
  - state IDLE, credit 0, sales 0
  - vend 0, chg 0, coin_rej 0, busy 0
- Reset mid-VEND or mid-CHANGE aborts: no vend, remaining change is lost, sales is not incremented for the aborted sale.
- A coin sampled at edge k that reaches PRICE gives vend = 1 during cycle k..k+1. sales updates at edge k+1.
- Change of N units: chg high for N consecutive cycles starting at edge k+1. IDLE is reached at edge k+1+N.
- Refund of N units: cancel sampled at edge k gives chg high for cycles k..k+N.
- coin_rej asserts one cycle after the rejected coin's sampling edge, for exactly one cycle per rejected sample.
- Minimum coin-to-coin acceptance spacing is 1 cycle in IDLE/COLLECT.

## Test plan
- Defaults; coin 01, 01, 01 on consecutive edges → credit 1, 2; then vend = 1 with credit 0; back to IDLE; sales = 1; chg never asserted.
- Coin 11 (5) from IDLE → vend = 1 with credit 2 for one cycle, then chg = 1 for 2 cycles (credit 2, 1), then IDLE with credit 0; sales = 1.
- Coin 10, then cancel → credit 2, then CHANGE: chg for 2 cycles, vend never asserted, sales unchanged.
- Coin 11, then coin 01 during VEND and again during CHANGE → two coin_rej pulses, each one cycle late; change count stays 2.
- Coin 01 with cancel asserted in COLLECT (credit 1) → coin_rej = 1 and exactly 1 chg cycle. Cancel in IDLE → no output activity.
- CNT_W = 2, run 5 sales → sales 1, 2, 3, 0, 1. Assert rst during a CHANGE → all outputs 0 immediately, sales 0, and the next coin is accepted normally.

Source files
------------

// File: rtl/vending_machine_p.sv
// Multi-coin vending controller: accumulates credit, pulses vend, then
// returns change one unit per cycle; rejects coins while busy.
module vending_machine_p #(
  parameter int PRICE     = 3,
  parameter int COIN3_VAL = 5,
  parameter int CW        = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       coin,
  input  logic             cancel,
  output logic             vend,
  output logic             chg,
  output logic             coin_rej,
  output logic             busy,
  output logic [CW-1:0]    credit,
  output logic [CNT_W-1:0] sales
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);
  localparam logic [CW:0] C3_W    = (CW+1)'(COIN3_VAL);

  state_t        state, state_n;
  logic [CW-1:0] credit_n;
  logic [CW:0]   val, sum;
  logic          rej_n;

  always_comb begin
    val = '0;
    unique case (coin)
      2'b01:   val = (CW+1)'(1);
      2'b10:   val = (CW+1)'(2);
      2'b11:   val = C3_W;
      default: val = '0;
    endcase
  end

  assign sum = {1'b0, credit} + val;

  always_comb begin
    state_n  = state;
    credit_n = credit;
    rej_n    = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        // cancel only means refund once there is credit to refund
        if (cancel && state == COLLECT) begin
          state_n = CHANGE;
          rej_n   = |coin;
        end else if (|coin) begin
          if (sum >= PRICE_W) begin
            state_n  = VEND;
            credit_n = CW'(sum - PRICE_W);
          end else begin
            state_n  = COLLECT;
            credit_n = sum[CW-1:0];
          end
        end
      end
      VEND: begin
        rej_n   = |coin;
        state_n = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_n    = |coin;
        credit_n = credit - CW'(1);
        if (credit == CW'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      credit   <= '0;
      sales    <= '0;
      coin_rej <= 1'b0;
    end else begin
      state    <= state_n;
      credit   <= credit_n;
      coin_rej <= rej_n;
      if (state == VEND) sales <= sales + CNT_W'(1);
    end
  end

  assign vend = (state == VEND);
  assign chg  = (state == CHANGE);
  assign busy = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_vending_machine_p.sv
// Directed bench for vending_machine_p: default instance plus a
// 2-bit sales counter instance for wrap checking.
module tb_vending_machine_p;

  logic       clk;
  logic       rst;
  logic [1:0] coin, coin_b;
  logic       cancel, cancel_b;
  logic       vend, chg, coin_rej, busy;
  logic [3:0] credit;
  logic [7:0] sales;
  logic       vend_b, chg_b, rej_b, busy_b;
  logic [3:0] credit_b;
  logic [1:0] sales_b;
  logic [7:0] obs;
  int         total = 0;
  int         bad = 0;

  vending_machine_p dut (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel),
    .vend(vend), .chg(chg), .coin_rej(coin_rej), .busy(busy),
    .credit(credit), .sales(sales)
  );

  vending_machine_p #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .coin(coin_b), .cancel(cancel_b),
    .vend(vend_b), .chg(chg_b), .coin_rej(rej_b), .busy(busy_b),
    .credit(credit_b), .sales(sales_b)
  );

  // obs = {vend, chg, coin_rej, busy, credit}
  assign obs = {vend, chg, coin_rej, busy, credit};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; coin = 2'b00; cancel = 1'b0;
    coin_b = 2'b00; cancel_b = 1'b0;
    tick; tick;
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL reset_out got=%h want=%h", obs, 8'h00);
    end
    total++;
    if (sales !== 8'd0) begin
      bad++; $display("FAIL reset_sales got=%0d want=0", sales);
    end
    rst = 1'b0;
  endtask

  task automatic test_exact;
    coin = 2'b01; tick;
    total++;
    if (obs !== {4'b0000, 4'd1}) begin
      bad++; $display("FAIL exact_c1 got=%h want=%h", obs, {4'b0000, 4'd1});
    end
    tick;
    total++;
    if (obs !== {4'b0000, 4'd2}) begin
      bad++; $display("FAIL exact_c2 got=%h want=%h", obs, {4'b0000, 4'd2});
    end
    tick;
    total++;
    if (obs !== {4'b1001, 4'd0}) begin
      bad++; $display("FAIL exact_vend got=%h want=%h", obs, {4'b1001, 4'd0});
    end
    coin = 2'b00; tick;
    total++;
    if (obs !== 8'h00 || sales !== 8'd1) begin
      bad++; $display("FAIL exact_idle got=%h/%0d want=00/1", obs, sales);
    end
  endtask

  task automatic test_change;
    coin = 2'b11; tick;
    total++;
    if (obs !== {4'b1001, 4'd2}) begin
      bad++; $display("FAIL chg_vend got=%h want=%h", obs, {4'b1001, 4'd2});
    end
    coin = 2'b00; tick;
    total++;
    if (obs !== {4'b0101, 4'd2} || sales !== 8'd2) begin
      bad++; $display("FAIL chg_c2 got=%h/%0d want=52/2", obs, sales);
    end
    tick;
    total++;
    if (obs !== {4'b0101, 4'd1}) begin
      bad++; $display("FAIL chg_c1 got=%h want=%h", obs, {4'b0101, 4'd1});
    end
    tick;
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL chg_idle got=%h want=00", obs);
    end
  endtask

  task automatic test_refund;
    coin = 2'b10; tick;
    total++;
    if (obs !== {4'b0000, 4'd2}) begin
      bad++; $display("FAIL ref_coll got=%h want=%h", obs, {4'b0000, 4'd2});
    end
    coin = 2'b00; cancel = 1'b1; tick;
    total++;
    if (obs !== {4'b0101, 4'd2}) begin
      bad++; $display("FAIL ref_c2 got=%h want=%h", obs, {4'b0101, 4'd2});
    end
    cancel = 1'b0; tick;
    total++;
    if (obs !== {4'b0101, 4'd1}) begin
      bad++; $display("FAIL ref_c1 got=%h want=%h", obs, {4'b0101, 4'd1});
    end
    tick;
    total++;
    if (obs !== 8'h00 || sales !== 8'd2) begin
      bad++; $display("FAIL ref_idle got=%h/%0d want=00/2", obs, sales);
    end
  endtask

  task automatic test_reject;
    coin = 2'b11; tick;
    coin = 2'b01; tick;
    total++;
    if (obs !== {4'b0111, 4'd2}) begin
      bad++; $display("FAIL rej_v got=%h want=%h", obs, {4'b0111, 4'd2});
    end
    coin = 2'b00; tick;
    total++;
    if (obs !== {4'b0101, 4'd1}) begin
      bad++; $display("FAIL rej_gap got=%h want=%h", obs, {4'b0101, 4'd1});
    end
    coin = 2'b01; tick;
    total++;
    if (obs !== {4'b0010, 4'd0}) begin
      bad++; $display("FAIL rej_c got=%h want=%h", obs, {4'b0010, 4'd0});
    end
    coin = 2'b00; tick;
    total++;
    if (obs !== 8'h00 || sales !== 8'd3) begin
      bad++; $display("FAIL rej_end got=%h/%0d want=00/3", obs, sales);
    end
  endtask

  task automatic test_cancel;
    coin = 2'b01; tick;
    cancel = 1'b1; tick;
    total++;
    if (obs !== {4'b0111, 4'd1}) begin
      bad++; $display("FAIL can_coll got=%h want=%h", obs, {4'b0111, 4'd1});
    end
    coin = 2'b00; cancel = 1'b0; tick;
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL can_done got=%h want=00", obs);
    end
    cancel = 1'b1; tick;
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL can_idle got=%h want=00", obs);
    end
    coin = 2'b01; tick;
    total++;
    if (obs !== {4'b0000, 4'd1}) begin
      bad++; $display("FAIL can_idle_coin got=%h want=%h", obs, {4'b0000, 4'd1});
    end
    coin = 2'b10; cancel = 1'b0; tick;
    total++;
    if (obs !== {4'b1001, 4'd0}) begin
      bad++; $display("FAIL can_vend got=%h want=%h", obs, {4'b1001, 4'd0});
    end
    coin = 2'b00; tick;
    total++;
    if (sales !== 8'd4) begin
      bad++; $display("FAIL can_sales got=%0d want=4", sales);
    end
  endtask

  task automatic test_wrap;
    logic [1:0] exp_s [5];
    exp_s = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      coin_b = 2'b10; tick;
      coin_b = 2'b01; tick;
      coin_b = 2'b00; tick;
      total++;
      if (sales_b !== exp_s[i] || busy_b !== 1'b0) begin
        bad++;
        $display("FAIL wrap_%0d got=%0d want=%0d", i, sales_b, exp_s[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    coin = 2'b11; tick;
    coin = 2'b00; tick;
    rst = 1'b1; #1;
    total++;
    if (obs !== 8'h00 || sales !== 8'd0) begin
      bad++; $display("FAIL rst_mid got=%h/%0d want=00/0", obs, sales);
    end
    tick;
    rst = 1'b0;
    coin = 2'b10; tick;
    total++;
    if (obs !== {4'b0000, 4'd2}) begin
      bad++; $display("FAIL rst_coin got=%h want=%h", obs, {4'b0000, 4'd2});
    end
    coin = 2'b01; tick;
    total++;
    if (obs !== {4'b1001, 4'd0}) begin
      bad++; $display("FAIL rst_vend got=%h want=%h", obs, {4'b1001, 4'd0});
    end
    coin = 2'b00; tick;
    total++;
    if (sales !== 8'd1 || obs !== 8'h00) begin
      bad++; $display("FAIL rst_sales got=%0d want=1", sales);
    end
  endtask

  initial begin
    test_reset;
    test_exact;
    test_change;
    test_refund;
    test_reject;
    test_cancel;
    test_wrap;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
